// File: rtl/seg_display_reader_pkg.sv
// Shared seven-segment definitions: active-low glyphs ordered {g,f,e,d,c,b,a}
// and the reader FSM encodings, shared by the reader and the display driver.
package seg7_pkg;

   localparam logic [6:0] GLYPH_0     = 7'h40;
   localparam logic [6:0] GLYPH_1     = 7'h79;
   localparam logic [6:0] GLYPH_2     = 7'h24;
   localparam logic [6:0] GLYPH_3     = 7'h30;
   localparam logic [6:0] GLYPH_4     = 7'h19;
   localparam logic [6:0] GLYPH_5     = 7'h12;
   localparam logic [6:0] GLYPH_6     = 7'h02;
   localparam logic [6:0] GLYPH_7     = 7'h78;
   localparam logic [6:0] GLYPH_8     = 7'h00;
   localparam logic [6:0] GLYPH_9     = 7'h10;
   localparam logic [6:0] GLYPH_A     = 7'h08;
   localparam logic [6:0] GLYPH_B     = 7'h03;
   localparam logic [6:0] GLYPH_C     = 7'h46;
   localparam logic [6:0] GLYPH_D     = 7'h21;
   localparam logic [6:0] GLYPH_E     = 7'h06;
   localparam logic [6:0] GLYPH_F     = 7'h0E;
   localparam logic [6:0] GLYPH_BLANK = 7'h7F;

   localparam logic [3:0] ENS_NONE    = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HELD   = 2'd2
   } seg7_state_t;

   // Exactly one digit enable driven low.
   function automatic logic is_one_cold(input logic [3:0] ens);
      return (ens == 4'b1110) || (ens == 4'b1101) ||
             (ens == 4'b1011) || (ens == 4'b0111);
   endfunction

   function automatic logic [1:0] digit_index(input logic [3:0] ens);
      logic [1:0] idx;
      idx = 2'd0;
      case (ens)
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/seg_display_reader_decode.sv
// Active-low seven-segment glyph to hex nibble lookup; anything outside the
// sixteen hex glyphs is reported as not legal.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       legal
);

   always_comb begin
      nibble = 4'h0;
      legal  = 1'b1;
      case (pattern)
         GLYPH_0: nibble = 4'h0;
         GLYPH_1: nibble = 4'h1;
         GLYPH_2: nibble = 4'h2;
         GLYPH_3: nibble = 4'h3;
         GLYPH_4: nibble = 4'h4;
         GLYPH_5: nibble = 4'h5;
         GLYPH_6: nibble = 4'h6;
         GLYPH_7: nibble = 4'h7;
         GLYPH_8: nibble = 4'h8;
         GLYPH_9: nibble = 4'h9;
         GLYPH_A: nibble = 4'hA;
         GLYPH_B: nibble = 4'hB;
         GLYPH_C: nibble = 4'hC;
         GLYPH_D: nibble = 4'hD;
         GLYPH_E: nibble = 4'hE;
         GLYPH_F: nibble = 4'hF;
         default: legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_display_reader.sv
// Reads a multiplexed, active-low four-digit seven-segment display back into
// a 16-bit hex value, capturing each digit once after its sample settles.
module seg_display_reader
   import seg7_pkg::*;
#(
   parameter int STABLE_CNT = 4,
   parameter int TIMEOUT    = 65535
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic [3:0]  ENs,
   input  logic [6:0]  BCDs,
   output logic [15:0] value,
   output logic [3:0]  digit_valid,
   output logic        frame_done,
   output logic        decode_err,
   output logic [1:0]  fsm_state
);

   localparam logic [7:0]  CNT_LAST = 8'(STABLE_CNT - 1);
   localparam logic [15:0] TO_MAX   = 16'(TIMEOUT);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

   logic [3:0] ens_s1, ens_s2, ens_prev;
   logic [6:0] bcds_s1, bcds_s2, bcds_prev;
   logic       sample_chg;

   // Two-stage synchronizer plus a one-sample history for change detection;
   // everything resets to the blank display so reset itself is not a change.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         ens_s1    <= ENS_NONE;
         ens_s2    <= ENS_NONE;
         ens_prev  <= ENS_NONE;
         bcds_s1   <= GLYPH_BLANK;
         bcds_s2   <= GLYPH_BLANK;
         bcds_prev <= GLYPH_BLANK;
      end else begin
         ens_s1    <= ENs;
         ens_s2    <= ens_s1;
         ens_prev  <= ens_s2;
         bcds_s1   <= BCDs;
         bcds_s2   <= bcds_s1;
         bcds_prev <= bcds_s2;
      end
   end

   assign sample_chg = ({ens_s2, bcds_s2} != {ens_prev, bcds_prev});

   seg7_state_t state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        capture;

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Any sample change restarts the window, whatever the current state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (sample_chg) begin
         if (is_one_cold(ens_s2)) begin
            state_d = ST_SETTLE;
            cnt_d   = 8'd1;
         end else begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
         end
      end else if (state_q == ST_SETTLE) begin
         cnt_d = cnt_q + 8'd1;
         if (cnt_q == CNT_LAST) begin
            state_d = ST_HELD;
         end
      end
   end

   always_comb begin
      capture = (state_q == ST_SETTLE) && !sample_chg && (cnt_q == CNT_LAST);
   end

   assign fsm_state = state_q;

   logic [3:0] dec_nibble;
   logic       dec_legal;
   logic [1:0] dig_idx;

   seg7_decode u_decode (
      .pattern (bcds_s2),
      .nibble  (dec_nibble),
      .legal   (dec_legal)
   );

   assign dig_idx = digit_index(ens_s2);

   logic [3:0][3:0] nib_q, nib_d;
   logic [3:0]      pend_q, pend_d;
   logic [3:0]      valid_d;
   logic            err_d;
   logic [15:0]     value_d;
   logic            frame_d;
   logic [15:0]     tcnt_q, tcnt_d;

   // A full pending set publishes on the following edge; a capture landing on
   // that same edge is applied after the clear so it seeds the next frame.
   always_comb begin
      nib_d   = nib_q;
      pend_d  = pend_q;
      valid_d = digit_valid;
      err_d   = decode_err;
      value_d = value;
      frame_d = 1'b0;
      tcnt_d  = tcnt_q;

      if (pend_q == 4'hF) begin
         value_d = nib_q;
         frame_d = 1'b1;
         pend_d  = 4'h0;
      end

      if (capture) begin
         tcnt_d = 16'd0;
         if (dec_legal) begin
            nib_d[dig_idx]   = dec_nibble;
            pend_d[dig_idx]  = 1'b1;
            valid_d[dig_idx] = 1'b1;
         end else begin
            pend_d[dig_idx]  = 1'b0;
            valid_d[dig_idx] = 1'b0;
            err_d            = 1'b1;
         end
      end else begin
         if (tcnt_q != TO_MAX) begin
            tcnt_d = tcnt_q + 16'd1;
         end
         if (tcnt_q == TO_LAST) begin
            valid_d = 4'h0;
            pend_d  = 4'h0;
         end
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         nib_q       <= '0;
         pend_q      <= 4'h0;
         digit_valid <= 4'h0;
         decode_err  <= 1'b0;
         value       <= 16'h0000;
         frame_done  <= 1'b0;
         tcnt_q      <= 16'd0;
      end else begin
         nib_q       <= nib_d;
         pend_q      <= pend_d;
         digit_valid <= valid_d;
         decode_err  <= err_d;
         value       <= value_d;
         frame_done  <= frame_d;
         tcnt_q      <= tcnt_d;
      end
   end

endmodule

// File: tb/tb_seg_display_reader.sv
// Directed bench for seg_display_reader: a sample-run model predicts every
// output each cycle, and literal expectations pin the headline scenarios.
module tb_seg_display_reader;
   import seg7_pkg::*;

   localparam int STABLE = 4;
   localparam int TMO    = 100;

   logic        sysclk = 1'b0;
   logic        reset  = 1'b1;
   logic [3:0]  ens    = 4'hF;
   logic [6:0]  bcds   = 7'h7F;
   logic [15:0] value;
   logic [3:0]  digit_valid;
   logic        frame_done;
   logic        decode_err;
   logic [1:0]  fsm_state;

   int n_tests = 0;
   int n_fail  = 0;
   int fd_cnt  = 0;
   int fd_before;

   always #5 sysclk = ~sysclk;

   seg_display_reader #(
      .STABLE_CNT (STABLE),
      .TIMEOUT    (TMO)
   ) dut (
      .sysclk      (sysclk),
      .reset       (reset),
      .ENs         (ens),
      .BCDs        (bcds),
      .value       (value),
      .digit_valid (digit_valid),
      .frame_done  (frame_done),
      .decode_err  (decode_err),
      .fsm_state   (fsm_state)
   );

   // Active-high segment images of 0..F; the display drives their inverse.
   logic [6:0] seg_on [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   function automatic logic [6:0] glyph(input int n);
      return ~seg_on[n];
   endfunction

   function automatic logic one_cold(input logic [3:0] e);
      return $countones(~e) == 1;
   endfunction

   function automatic int digit_of(input logic [3:0] e);
      int d;
      d = 0;
      for (int k = 0; k < 4; k++) if (e[k] == 1'b0) d = k;
      return d;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] exp_q[$];
   logic        model_ok = 1'b0;
   logic [10:0] m_last;
   int          m_run;
   logic [1:0]  pv;
   logic [10:0] pp [2];
   logic [3:0]  m_nib [4];
   logic [3:0]  m_pend, m_dv;
   logic        m_err, m_fd;
   logic [15:0] m_val;
   int          m_since;

   // A digit is taken two edges after its sample has been seen STABLE times in a row.
   always @(posedge sysclk) begin : model
      logic [10:0] samp;
      logic        c;
      logic [10:0] cp;
      logic        ok;
      logic [3:0]  nv;
      int          di;
      if (reset) begin
         model_ok = 1'b1;
         m_last   = '1;
         m_run    = 1;
         pv       = 2'b00;
         m_val    = 16'h0;
         m_dv     = 4'h0;
         m_pend   = 4'h0;
         m_err    = 1'b0;
         m_fd     = 1'b0;
         m_since  = 0;
         for (int k = 0; k < 4; k++) m_nib[k] = 4'h0;
      end else begin
         c     = pv[1];
         cp    = pp[1];
         pv[1] = pv[0];
         pp[1] = pp[0];
         samp  = {ens, bcds};
         if (samp == m_last) m_run++;
         else m_run = 1;
         m_last = samp;
         pv[0]  = (m_run == STABLE) && one_cold(samp[10:7]);
         pp[0]  = samp;

         m_fd = (m_pend == 4'hF);
         if (m_fd) begin
            m_val  = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
            m_pend = 4'h0;
            exp_q.push_back(m_val);
         end
         if (c) begin
            m_since = 0;
            di = digit_of(cp[10:7]);
            ok = 1'b0;
            nv = 4'h0;
            for (int k = 0; k < 16; k++) begin
               if (glyph(k) == cp[6:0]) begin
                  ok = 1'b1;
                  nv = 4'(k);
               end
            end
            if (ok) begin
               m_nib[di]  = nv;
               m_pend[di] = 1'b1;
               m_dv[di]   = 1'b1;
            end else begin
               m_pend[di] = 1'b0;
               m_dv[di]   = 1'b0;
               m_err      = 1'b1;
            end
         end else begin
            m_since++;
            if (m_since == TMO) begin
               m_dv   = 4'h0;
               m_pend = 4'h0;
            end
         end
      end
   end

   // ---------------- per-cycle compare / scoreboard ----------------
   always @(negedge sysclk) begin
      if (model_ok) begin
         check("value", value, m_val);
         check("digit_valid", digit_valid, m_dv);
         check("frame_done", frame_done, m_fd);
         check("decode_err", decode_err, m_err);
         if (frame_done) begin
            fd_cnt++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL frame_unexpected: got frame_done=1, expected no frame at %0t", $time);
            end else begin
               check("frame_value", value, exp_q.pop_front());
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [3:0] e, input logic [6:0] b, input int cycles);
      ens  = e;
      bcds = b;
      repeat (cycles) @(negedge sysclk);
   endtask

   task automatic scan(input logic [6:0] d3, input logic [6:0] d2,
                       input logic [6:0] d1, input logic [6:0] d0);
      drive(4'b0111, d3, 10);
      drive(4'b1011, d2, 10);
      drive(4'b1101, d1, 10);
      drive(4'b1110, d0, 10);
      drive(4'hF, 7'h7F, 4);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      repeat (3) @(negedge sysclk);
      check("rst_value", value, 16'h0000);
      check("rst_valid", digit_valid, 4'h0);
      check("rst_frame", frame_done, 1'b0);
      check("rst_err", decode_err, 1'b0);
      check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
      reset = 1'b0;

      // Full scan of "13A0".
      fd_before = fd_cnt;
      scan(7'h79, 7'h30, 7'h08, 7'h40);
      check("scan_frames", fd_cnt - fd_before, 1);
      check("scan_value", value, 16'h13A0);
      check("scan_valid", digit_valid, 4'hF);

      // Three-cycle glitch on digit 0 must not be captured.
      fd_before = fd_cnt;
      drive(4'b1110, glyph(2), 3);
      drive(4'hF, 7'h7F, 8);
      check("glitch_frames", fd_cnt - fd_before, 0);
      check("glitch_valid", digit_valid, 4'hF);
      check("glitch_value", value, 16'h13A0);

      // Blank pattern on digit 2 holds the frame until a legal digit 2 arrives.
      fd_before = fd_cnt;
      scan(glyph(9), 7'h7F, glyph(5), glyph(4));
      check("blank_err", decode_err, 1'b1);
      check("blank_valid", digit_valid, 4'b1011);
      check("blank_frames", fd_cnt - fd_before, 0);
      drive(4'b1011, glyph(2), 10);
      drive(4'hF, 7'h7F, 4);
      check("fix_frames", fd_cnt - fd_before, 1);
      check("fix_value", value, 16'h9254);
      check("fix_valid", digit_valid, 4'hF);

      // Two enables low at once: stays idle, nothing captured.
      fd_before = fd_cnt;
      ens  = 4'b1100;
      bcds = 7'h00;
      for (int i = 0; i < 20; i++) begin
         @(negedge sysclk);
         check("twohot_state", 32'(fsm_state), 32'(ST_IDLE));
      end
      drive(4'hF, 7'h7F, 4);
      check("twohot_valid", digit_valid, 4'hF);
      check("twohot_frames", fd_cnt - fd_before, 0);
      check("twohot_value", value, 16'h9254);

      // Reset after three of four digits discards the partial frame.
      drive(4'b0111, glyph(15), 10);
      drive(4'b1011, glyph(14), 10);
      drive(4'b1101, glyph(13), 10);
      drive(4'b1110, glyph(12), 3);
      reset = 1'b1;
      drive(4'hF, 7'h7F, 2);
      check("mid_rst_value", value, 16'h0000);
      check("mid_rst_valid", digit_valid, 4'h0);
      check("mid_rst_frame", frame_done, 1'b0);
      check("mid_rst_err", decode_err, 1'b0);
      check("mid_rst_state", 32'(fsm_state), 32'(ST_IDLE));
      reset = 1'b0;
      fd_before = fd_cnt;
      scan(glyph(8), glyph(7), glyph(6), glyph(5));
      check("post_rst_frames", fd_cnt - fd_before, 1);
      check("post_rst_value", value, 16'h8765);

      // Timeout: partial frame, then a long blank clears valid and pending bits.
      fd_before = fd_cnt;
      drive(4'b0111, glyph(1), 10);
      drive(4'b1011, glyph(2), 10);
      drive(4'b1101, glyph(3), 10);
      drive(4'hF, 7'h7F, 50);
      check("pre_to_valid", digit_valid, 4'hF);
      drive(4'hF, 7'h7F, 55);
      check("to_valid", digit_valid, 4'h0);
      check("to_value", value, 16'h8765);
      drive(4'b1110, glyph(4), 10);
      drive(4'hF, 7'h7F, 4);
      check("to_frames", fd_cnt - fd_before, 0);
      check("to_single_valid", digit_valid, 4'b0001);
      check("to_err", decode_err, 1'b0);

      check("frame_queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
